pipe_pulse_train_gen: RTL and testbench
=======================================

# pipe_pulse_train_gen

Multi-channel, programmable successor to the single-channel pipe pulse stage. Each channel detects a rising edge on its monitored signal, or a level on its pipeline input. It then waits a programmable delay and drives a registered pulse of programmable width on its pipeline output. Retrigger behaviour is selectable and dropped triggers are reported. Channels are independent and chain stage-to-stage through `pipe_out` → `pipe_in`.

## Interface
- `CHANNELS`, default 4: number of independent channels (≥1).
- `CNT_W`, default 8: width of the delay and width counters (≥1).

- `clk`  in  1  — single clock; one clock; reset is asynchronous and active-low.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `s`  in  CHANNELS  — monitored signals; bit i is used by channel i.
- `pipe_in`  in  CHANNELS  — pipeline inputs; level-sensitive trigger.
- `enable`  in  CHANNELS  — per-channel enable.
- `cfg_delay`  in  CNT_W  — delay D in cycles; shared by all channels.
- `cfg_width`  in  CNT_W  — pulse width W in cycles; 0 is treated as 1.
- `cfg_retrigger`  in  1  — 0 = ignore triggers while busy; 1 = restart on trigger.
- `overrun_clr`  in  1  — clears all overrun flags.
- `pipe_out`  out  CHANNELS  — registered pulse outputs.
- `busy`  out  CHANNELS  — registered; channel is not IDLE.
- `overrun`  out  CHANNELS  — sticky; a trigger was dropped.

## Operation
- Per channel i, `s_prev[i]` is registered from `s[i]` every cycle, regardless of `enable`.
- Trigger: `trig[i] = enable[i] & ((s[i] & ~s_prev[i]) | pipe_in[i])`.
- Three-state FSM per channel: IDLE, DELAY, PULSE. Each channel has a CNT_W down-counter plus a latched width `w_lat`.
- Config is latched at trigger acceptance. Changing `cfg_*` never affects an operation already in flight.
- Accepting state: IDLE, or PULSE with counter == 0 (last pulse cycle).
- Accept (from an accepting state, or from any state when `cfg_retrigger=1`):
  - If D == 0: go to PULSE with counter = max(W,1) − 1.
  - Else: go to DELAY with counter = D − 1.
  - In both cases, `w_lat = max(W,1)`.
- DELAY: when counter == 0, go to PULSE with counter = `w_lat` − 1. Otherwise decrement.
- PULSE: when counter == 0 and there is no accepted trigger, go to IDLE. Otherwise decrement.
- Trigger in DELAY, or in PULSE with counter ≠ 0, with `cfg_retrigger=0`: the trigger is dropped, `overrun[i]` is set, and the operation continues unchanged.
- `enable[i]` low: the channel is forced to IDLE on the next edge, aborting any operation. `overrun` is held.
- `pipe_out[i]` is registered high exactly when the next state is PULSE. `busy[i]` is registered high when the next state is not IDLE.
- `overrun_clr` clears all flags. If a set and a clear occur in the same cycle, the set wins.
- Reset: all FSMs go to IDLE, counters to 0, `s_prev` to 0, and `pipe_out`, `busy`, `overrun` to 0.
- Because `s_prev` resets to 0, `s` high at the first edge after reset counts as a rising edge.

## Timing
- Trigger sampled at edge k:
  - `pipe_out` rises after edge k+D.
  - `pipe_out` falls after edge k+D+W, giving exactly W cycles high (W=0 gives 1 cycle).
  - `busy` is high from after edge k until `pipe_out` falls.
- With D=0, latency is 1 cycle from trigger presentation to `pipe_out`.
- A trigger on the last PULSE cycle (edge k+D+W−1) with D=0 extends `pipe_out` seamlessly with no low gap.
- Retrigger=1 during PULSE: the new timing is measured from the retrigger edge. `pipe_out` goes low after that edge if D>0.
- `pipe_in` held high: with retrigger=0, back-to-back accepts occur every W+D cycles and overrun is set in between. With retrigger=1, the channel is re-armed every cycle.
- Asynchronous `rst_n` assertion mid-operation clears all outputs immediately. The first accept is possible at the first edge after deassertion.
- Counter arithmetic is unsigned CNT_W bits. D and W values up to 2^CNT_W−1 are valid, with no wrap.

## Test plan
- Chain ch0→ch1 (`pipe_out[0]` → `pipe_in[1]`), D=0, W=1, single `s[0]` edge at k -> `pipe_out[0]` high only in cycle k+1, `pipe_out[1]` high only in cycle k+2.
- Ch0, D=3, W=4, `s` rises at edge 10 -> `busy` goes 1 after edge 10; `pipe_out` is 1 after edges 13..16 and 0 after edge 17; `busy` goes 0 after edge 17.
- D=5, W=2, retrigger=0, second `s` edge at k+2 -> single pulse at k+5..k+6, `overrun=1`; `overrun_clr` pulse -> `overrun=0`, and a same-cycle new overrun keeps it 1.
- D=5, W=2, retrigger=1, second edge at k+2 -> no pulse at k+5; pulse at k+7..k+8; `overrun` stays 0.
- D=0, W=3, `pipe_in` held high 6 cycles, retrigger=0 -> `pipe_out` continuously high for 6 cycles with no gap, `overrun=1`. W=0 gives 1-cycle pulses.
- `cfg_delay` changed mid-DELAY -> latched timing is unaffected. `enable` dropped mid-PULSE -> `pipe_out` and `busy` are 0 next cycle. `rst_n` low mid-PULSE -> all outputs 0 immediately, and `s` high at release gives a trigger on the first edge.

Source files
------------

// File: rtl/pipe_pulse_train_gen.sv
// pipe_pulse_train_gen
//
// Multi-channel programmable pulse-train stage. Each channel watches a
// rising edge on its monitored signal s[i], or a level on its pipeline
// input pipe_in[i]. When it accepts a trigger it waits cfg_delay cycles
// and then drives a registered pulse of cfg_width cycles (0 acts as 1) on
// pipe_out[i]. Channels are independent and may be chained through
// pipe_out -> pipe_in. The delay and width are latched when a trigger is
// accepted, so later config changes never disturb a pulse in flight.
//
// Ports
//   clk           : single clock
//   rst_n         : asynchronous active-low reset
//   s             : monitored signals, rising edge triggers channel i
//   pipe_in       : pipeline inputs, level triggers channel i
//   enable        : per-channel enable; low forces the channel to IDLE
//   cfg_delay     : delay D in cycles, shared by all channels
//   cfg_width     : pulse width W in cycles, shared, 0 is treated as 1
//   cfg_retrigger : 0 = drop triggers while busy, 1 = restart on trigger
//   overrun_clr   : clears every overrun flag (a same-cycle set wins)
//   pipe_out      : registered pulse outputs
//   busy          : registered, channel is not IDLE
//   overrun       : sticky, a trigger was dropped on this channel

module pipe_pulse_train_gen #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] s,
    input  logic [CHANNELS-1:0] pipe_in,
    input  logic [CHANNELS-1:0] enable,
    input  logic [CNT_W-1:0]    cfg_delay,
    input  logic [CNT_W-1:0]    cfg_width,
    input  logic                cfg_retrigger,
    input  logic                overrun_clr,
    output logic [CHANNELS-1:0] pipe_out,
    output logic [CHANNELS-1:0] busy,
    output logic [CHANNELS-1:0] overrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        PULSE = 2'd2
    } state_t;

    logic [CHANNELS-1:0] sPrev_q;
    logic [CNT_W-1:0]    widthEff;

    // A width of zero still produces a one-cycle pulse.
    assign widthEff = (cfg_width == '0) ? CNT_W'(1) : cfg_width;

    // The edge-detect history follows s every cycle, independent of enable,
    // so that re-enabling a channel never sees a stale rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sPrev_q <= '0;
        end else begin
            sPrev_q <= s;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : gChan
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] wLat_q, wLat_d;
        logic             pipeOut_q, busy_q, overrun_q, overrun_d;
        logic             trig, accepting, accept, drop;

        // A channel may take a new trigger when idle or on the final pulse
        // cycle; taking it on the final cycle lets a D=0 retrigger extend the
        // pulse with no low gap. With retrigger enabled any state accepts.
        always_comb begin
            trig      = enable[i] & ((s[i] & ~sPrev_q[i]) | pipe_in[i]);
            accepting = (state_q == IDLE) || ((state_q == PULSE) && (cnt_q == '0));
            accept    = trig & (accepting | cfg_retrigger);
            drop      = trig & ~accepting & ~cfg_retrigger;
        end

        // Next-state logic. Disable has priority and aborts the operation;
        // an accepted trigger latches the current config; otherwise the
        // counter runs down through DELAY and PULSE.
        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            wLat_d    = wLat_q;
            overrun_d = drop | (overrun_q & ~overrun_clr);
            if (!enable[i]) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else if (accept) begin
                wLat_d = widthEff;
                if (cfg_delay == '0) begin
                    state_d = PULSE;
                    cnt_d   = widthEff - CNT_W'(1);
                end else begin
                    state_d = DELAY;
                    cnt_d   = cfg_delay - CNT_W'(1);
                end
            end else begin
                case (state_q)
                    DELAY: begin
                        if (cnt_q == '0) begin
                            state_d = PULSE;
                            cnt_d   = wLat_q - CNT_W'(1);
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                    PULSE: begin
                        if (cnt_q == '0) begin
                            state_d = IDLE;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end

        // Outputs are registered from the next state so pipe_out and busy
        // line up exactly with the state the channel is entering.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q   <= IDLE;
                cnt_q     <= '0;
                wLat_q    <= '0;
                pipeOut_q <= 1'b0;
                busy_q    <= 1'b0;
                overrun_q <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                wLat_q    <= wLat_d;
                pipeOut_q <= (state_d == PULSE);
                busy_q    <= (state_d != IDLE);
                overrun_q <= overrun_d;
            end
        end

        assign pipe_out[i] = pipeOut_q;
        assign busy[i]     = busy_q;
        assign overrun[i]  = overrun_q;
    end

endmodule

// File: tb/tb_pipe_pulse_train_gen.sv
// Testbench for pipe_pulse_train_gen.
//
// The reference model tracks each channel as an absolute edge window:
// pipe_out is expected high after edges startCyc..endCyc-1 and busy after
// every edge before endCyc. A trigger at edge n is accepted when n >= endCyc
// (idle or last pulse cycle) or retrigger is on, and then sets
// startCyc = n + D, endCyc = n + D + max(W,1).

module tb_pipe_pulse_train_gen;

    localparam int CH = 4;
    localparam int CW = 8;

    logic          clk;
    logic          rst_n;
    logic [CH-1:0] s;
    logic [CH-1:0] pipeInRaw;
    logic [CH-1:0] pipe_in;
    logic [CH-1:0] enable;
    logic [CW-1:0] cfg_delay;
    logic [CW-1:0] cfg_width;
    logic          cfg_retrigger;
    logic          overrun_clr;
    logic          chainMode;
    logic [CH-1:0] pipe_out;
    logic [CH-1:0] busy;
    logic [CH-1:0] overrun;

    int compareCount  = 0;
    int mismatchCount = 0;

    longint        edgeNum = 0;
    longint        startCyc[CH];
    longint        endCyc[CH];
    logic [CH-1:0] modelSPrev = '0;
    logic [CH-1:0] expPipe    = '0;
    logic [CH-1:0] expBusy    = '0;
    logic [CH-1:0] expOvr     = '0;

    pipe_pulse_train_gen #(
        .CHANNELS(CH),
        .CNT_W   (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s            (s),
        .pipe_in      (pipe_in),
        .enable       (enable),
        .cfg_delay    (cfg_delay),
        .cfg_width    (cfg_width),
        .cfg_retrigger(cfg_retrigger),
        .overrun_clr  (overrun_clr),
        .pipe_out     (pipe_out),
        .busy         (busy),
        .overrun      (overrun)
    );

    // In chain mode channel 1 is fed by channel 0's pulse output.
    assign pipe_in = chainMode ? {pipeInRaw[CH-1:2], pipe_out[0], pipeInRaw[0]} : pipeInRaw;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [CH-1:0] observed,
                               input logic [CH-1:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s at edge %0d: got %b, expected %b", tag, edgeNum, observed, expected);
        end
    endtask

    // Advance the reference model by one clock edge using the inputs that
    // are stable at that edge.
    task automatic modelEdge();
        logic [CH-1:0] pin;
        logic          trig;
        logic          setOvr;
        longint        wEff;
        edgeNum++;
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) begin
                startCyc[i] = edgeNum;
                endCyc[i]   = edgeNum;
            end
            modelSPrev = '0;
            expPipe    = '0;
            expBusy    = '0;
            expOvr     = '0;
        end else begin
            pin  = chainMode ? {pipeInRaw[CH-1:2], expPipe[0], pipeInRaw[0]} : pipeInRaw;
            wEff = (cfg_width == 0) ? 1 : longint'(cfg_width);
            for (int i = 0; i < CH; i++) begin
                trig   = enable[i] & ((s[i] & ~modelSPrev[i]) | pin[i]);
                setOvr = 1'b0;
                if (!enable[i]) begin
                    startCyc[i] = edgeNum;
                    endCyc[i]   = edgeNum;
                end else if (trig) begin
                    if (edgeNum >= endCyc[i] || cfg_retrigger) begin
                        startCyc[i] = edgeNum + longint'(cfg_delay);
                        endCyc[i]   = startCyc[i] + wEff;
                    end else begin
                        setOvr = 1'b1;
                    end
                end
                expOvr[i]  = setOvr | (expOvr[i] & ~overrun_clr);
                expPipe[i] = (edgeNum >= startCyc[i]) && (edgeNum < endCyc[i]);
                expBusy[i] = (edgeNum < endCyc[i]);
            end
            modelSPrev = s;
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, then compare outputs
    // one time unit after the edge.
    task automatic applyStimulus(input logic [CH-1:0] sv, input logic [CH-1:0] pv,
                                 input logic [CH-1:0] ev);
        s         = sv;
        pipeInRaw = pv;
        enable    = ev;
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput("pipe_out", pipe_out, expPipe);
        checkOutput("busy", busy, expBusy);
        checkOutput("overrun", overrun, expOvr);
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) applyStimulus('0, '0, '1);
    endtask

    task automatic setCfg(input int d, input int w, input logic r);
        cfg_delay     = CW'(d);
        cfg_width     = CW'(w);
        cfg_retrigger = r;
    endtask

    // Asynchronous reset asserted away from a clock edge: outputs must drop
    // without waiting for the clock.
    task automatic asyncReset();
        rst_n = 1'b0;
        #1;
        checkOutput("async_pipe_out", pipe_out, '0);
        checkOutput("async_busy", busy, '0);
        checkOutput("async_overrun", overrun, '0);
        for (int i = 0; i < CH; i++) begin
            startCyc[i] = edgeNum;
            endCyc[i]   = edgeNum;
        end
        modelSPrev = '0;
        expPipe    = '0;
        expBusy    = '0;
        expOvr     = '0;
    endtask

    initial begin
        logic [31:0] r;
        logic [CH-1:0] pv;
        logic [CH-1:0] ev;
        for (int i = 0; i < CH; i++) begin
            startCyc[i] = 0;
            endCyc[i]   = 0;
        end
        s           = '0;
        pipeInRaw   = '0;
        enable      = '0;
        overrun_clr = 1'b0;
        chainMode   = 1'b0;
        setCfg(0, 1, 1'b0);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;

        // Reset state
        for (int k = 0; k < 3; k++) applyStimulus('0, '0, '1);
        rst_n = 1'b1;
        idleCycles(2);

        // Chain ch0 -> ch1 with D=0, W=1
        chainMode = 1'b1;
        setCfg(0, 1, 1'b0);
        applyStimulus(4'b0001, '0, '1);
        applyStimulus(4'b0001, '0, '1);
        idleCycles(4);
        chainMode = 1'b0;

        // D=3, W=4 single edge
        setCfg(3, 4, 1'b0);
        applyStimulus(4'b0001, '0, '1);
        idleCycles(10);

        // D=5, W=2, retrigger off: second edge dropped, then clear
        setCfg(5, 2, 1'b0);
        applyStimulus(4'b0001, '0, '1);
        applyStimulus(4'b0000, '0, '1);
        applyStimulus(4'b0001, '0, '1);
        idleCycles(7);
        overrun_clr = 1'b1;
        applyStimulus('0, '0, '1);
        overrun_clr = 1'b0;
        applyStimulus(4'b0001, '0, '1);
        applyStimulus(4'b0000, '0, '1);
        overrun_clr = 1'b1;
        applyStimulus(4'b0001, '0, '1);
        overrun_clr = 1'b0;
        idleCycles(8);
        overrun_clr = 1'b1;
        applyStimulus('0, '0, '1);
        overrun_clr = 1'b0;

        // Same case with retrigger on
        setCfg(5, 2, 1'b1);
        applyStimulus(4'b0001, '0, '1);
        applyStimulus(4'b0000, '0, '1);
        applyStimulus(4'b0001, '0, '1);
        idleCycles(9);

        // pipe_in held high, D=0, W=3 then W=0
        setCfg(0, 3, 1'b0);
        for (int k = 0; k < 6; k++) applyStimulus('0, 4'b0001, '1);
        idleCycles(4);
        setCfg(0, 0, 1'b0);
        for (int k = 0; k < 5; k++) applyStimulus('0, 4'b0001, '1);
        idleCycles(3);
        setCfg(2, 3, 1'b1);
        for (int k = 0; k < 5; k++) applyStimulus('0, 4'b0001, '1);
        idleCycles(6);
        overrun_clr = 1'b1;
        applyStimulus('0, '0, '1);
        overrun_clr = 1'b0;

        // Config changed mid-DELAY, then enable dropped mid-PULSE
        setCfg(6, 5, 1'b0);
        applyStimulus(4'b0001, '0, '1);
        applyStimulus('0, '0, '1);
        setCfg(1, 1, 1'b0);
        idleCycles(7);
        applyStimulus('0, '0, 4'b1110);
        idleCycles(3);

        // Maximum delay and width
        setCfg(255, 255, 1'b0);
        applyStimulus(4'b0010, '0, '1);
        idleCycles(515);

        // Reset mid-PULSE, s high at release triggers on the first edge
        setCfg(0, 8, 1'b0);
        applyStimulus(4'b0001, '0, '1);
        idleCycles(3);
        asyncReset();
        applyStimulus('0, '0, '1);
        applyStimulus('0, '0, '1);
        s     = 4'b0101;
        #2 rst_n = 1'b1;
        setCfg(0, 2, 1'b0);
        applyStimulus(4'b0101, '0, '1);
        idleCycles(4);

        // Randomized traffic with occasional config, clear and enable changes
        for (int k = 0; k < 3000; k++) begin
            if (k % 150 == 0) begin
                r = $urandom;
                setCfg(int'(r[2:0]), int'(r[5:3]), r[6]);
                if (r[11:8] == 4'hF) cfg_delay = CW'(r[20:16]);
            end else if ((k % 37) == 5) begin
                r = $urandom;
                cfg_delay = CW'(r[2:0]);
                cfg_width = CW'(r[5:3]);
            end
            r = $urandom;
            overrun_clr = (r[31:28] == 4'h0);
            for (int i = 0; i < CH; i++) begin
                pv[i] = (r[3*i +: 3] == 3'd0);
                ev[i] = (r[12 + 4*i +: 4] != 4'h0) | (r[27:24] != 4'h0);
            end
            r = $urandom;
            applyStimulus(r[CH-1:0], pv, ev);
        end
        overrun_clr = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
